// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory store buffer.
// sb_entry_t field widths follow DMEM_WIDTH / DMEM_ADDR_W.
package dmem_pkg;
    localparam int DMEM_WIDTH    = 32;
    localparam int DMEM_ADDR_W   = 7;
    localparam int DMEM_SB_DEPTH = 4;
    localparam int DMEM_WR_LAT   = 2;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] idx;
        logic [DMEM_WIDTH-1:0]  data;
    } sb_entry_t;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} drain_state_t;
endpackage

// File: rtl/data_mem_store_buffer_if.sv
// Core-side load/store bus of the data-memory stage.
interface data_mem_store_buffer_if #(parameter int WIDTH = 32);
    logic             MemWrite;
    logic             MemRead;
    logic [WIDTH-1:0] Addr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;
    logic             Stall;
    logic             SbEmpty;
    logic [31:0]      StallCount;
    logic [31:0]      FwdCount;

    modport master (output MemWrite, MemRead, Addr, WriteData,
                    input  ReadData, Stall, SbEmpty, StallCount, FwdCount);
    modport slave  (input  MemWrite, MemRead, Addr, WriteData,
                    output ReadData, Stall, SbEmpty, StallCount, FwdCount);
endinterface

// File: rtl/store_buffer_fifo.sv
// Store-buffer FIFO: entry storage, pointers, occupancy and youngest-match lookup.
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = DMEM_SB_DEPTH,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int WIDTH    = DMEM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  sb_entry_t                   push_entry,
    input  logic                        pop,
    input  logic [ADDR_W-1:0]           lookup_idx,
    output sb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(SB_DEPTH):0]   count,
    output logic                        hit,
    output logic [WIDTH-1:0]            hit_data
);
    localparam int PW = $clog2(SB_DEPTH);

    sb_entry_t       mem [SB_DEPTH];
    logic [PW-1:0]   hd, tl;

    always_ff @(posedge clk) begin
        if (rst) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else begin
            if (push) tl <= tl + PW'(1);
            if (pop)  hd <= hd + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tl] <= push_entry;
    end

    assign head  = mem[hd];
    assign full  = (count == (PW+1)'(SB_DEPTH));
    assign empty = (count == '0);

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (((PW+1)'(i) < count) && (mem[hd + PW'(i)].idx == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = mem[hd + PW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/data_mem_store_buffer.sv
// Data-memory stage: store buffer draining into a slow-write word RAM, with load forwarding.
// Optional perf counters under DMEM_PERF_CNT_EN.
module data_mem_store_buffer
    import dmem_pkg::*;
#(
    parameter int WIDTH    = DMEM_WIDTH,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int SB_DEPTH = DMEM_SB_DEPTH,
    parameter int WR_LAT   = DMEM_WR_LAT
) (
    input  logic                     CLK,
    input  logic                     RST,
    data_mem_store_buffer_if.slave   bus
);
    localparam int CW    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    drain_state_t       state;
    logic [CW-1:0]      lat_cnt;
    logic [ADDR_W-1:0]  idx;
    sb_entry_t          head, push_entry;
    logic               full, empty, hit;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hit_data;
    logic               drain_done, stall, push, more_left;
    logic [WIDTH-1:0]   ram [2**ADDR_W];

    assign idx        = bus.Addr[ADDR_W+1:2];
    assign push_entry = '{idx: idx, data: bus.WriteData};
    assign drain_done = (state == WRITE) && (lat_cnt == CW'(WR_LAT-1));
    assign stall      = bus.MemWrite && full && !drain_done;
    assign push       = bus.MemWrite && !stall;
    // drain_done implies count>=1, so anything but a lone entry leaves work behind.
    assign more_left  = (count != CNT_W'(1)) || push;

    store_buffer_fifo #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain_done),
        .lookup_idx (idx),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state   <= WRITE;
                    lat_cnt <= '0;
                end
                WRITE: if (drain_done) begin
                    state   <= more_left ? WRITE : IDLE;
                    lat_cnt <= '0;
                end else begin
                    lat_cnt <= lat_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset aborts an in-flight write, so RAM only commits outside reset.
    always_ff @(posedge CLK) begin
        if (!RST && drain_done) ram[head.idx] <= head.data;
    end

    assign bus.ReadData = hit ? hit_data : ram[idx];
    assign bus.Stall    = stall;
    assign bus.SbEmpty  = empty && (state == IDLE);

    logic unused_bits;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != '1)                  stall_cnt <= stall_cnt + 32'd1;
            if (bus.MemRead && hit && fwd_cnt != '1)       fwd_cnt   <= fwd_cnt + 32'd1;
        end
    end

    assign bus.StallCount = stall_cnt;
    assign bus.FwdCount   = fwd_cnt;
    assign unused_bits    = ^{bus.Addr[WIDTH-1:ADDR_W+2], bus.Addr[1:0]};
`else
    assign bus.StallCount = '0;
    assign bus.FwdCount   = '0;
    assign unused_bits    = ^{bus.Addr[WIDTH-1:ADDR_W+2], bus.Addr[1:0], bus.MemRead};
`endif
endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Bench for data_mem_store_buffer: directed table, hand-written corner sequences,
// and random traffic against a queue-based reference model.
module tb_data_mem_store_buffer;
    localparam int SB_DEPTH = 4;
    localparam int WR_LAT   = 2;
`ifdef DMEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    data_mem_store_buffer_if #(.WIDTH(32)) bus ();

    data_mem_store_buffer #(.WIDTH(32), .ADDR_W(7), .SB_DEPTH(SB_DEPTH), .WR_LAT(WR_LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference model: pending stores in age order, word RAM, and the cycle
    // on which the current head finishes its write (-1 when nothing is in flight).
    typedef struct { logic [6:0] idx; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic [31:0] ram_m [128];
    int          cyc = 0;
    int          done_at = -1;
    int          exp_stall_cnt = 0, exp_fwd_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic step(input logic rst_i, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic stalled, output logic o_stall,
                        output logic o_empty, output logic [31:0] o_rd);
        logic [6:0]  idx;
        logic        hit, dd, exp_stall, idle_nonempty;
        logic [31:0] exp_rd;
        RST = rst_i;
        bus.MemWrite = we;
        bus.MemRead = re;
        bus.Addr = addr;
        bus.WriteData = wd;
        idx = addr[8:2];
        dd = (done_at == cyc);
        exp_stall = we && (q.size() == SB_DEPTH) && !dd;
        hit = 1'b0;
        exp_rd = ram_m[idx];
        foreach (q[i]) if (q[i].idx == idx) begin hit = 1'b1; exp_rd = q[i].data; end
        @(negedge CLK);
        o_stall = bus.Stall;
        o_empty = bus.SbEmpty;
        o_rd = bus.ReadData;
        if (!rst_i) begin
            check("stall", bus.Stall, 32'(exp_stall));
            check("sb_empty", bus.SbEmpty, 32'(q.size() == 0 && done_at < 0));
            if (re && !we) check("read_data", bus.ReadData, exp_rd);
            check("stall_count", bus.StallCount, PERF ? 32'(exp_stall_cnt) : 32'd0);
            check("fwd_count", bus.FwdCount, PERF ? 32'(exp_fwd_cnt) : 32'd0);
        end
        stalled = exp_stall;
        if (rst_i) begin
            q.delete();
            done_at = -1;
            exp_stall_cnt = 0;
            exp_fwd_cnt = 0;
        end else begin
            idle_nonempty = (q.size() != 0) && (done_at < 0);
            if (exp_stall) exp_stall_cnt++;
            if (re && hit) exp_fwd_cnt++;
            if (dd) begin
                ram_m[q[0].idx] = q[0].data;
                void'(q.pop_front());
            end
            if (we && !exp_stall) q.push_back('{idx, wd});
            if (dd) done_at = (q.size() != 0) ? cyc + WR_LAT : -1;
            else if (idle_nonempty) done_at = cyc + WR_LAT;
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wd);
        logic st, os, oe;
        logic [31:0] rd;
        int tries = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, addr, wd, st, os, oe, rd);
            tries++;
        end while (st && tries < 50);
        if (st) begin
            n_chk++;
            $display("FAIL store_retry: still stalled after %0d cycles, required acceptance", tries);
        end
    endtask

    task automatic drain();
        logic st, os, oe;
        logic [31:0] rd;
        int t = 0;
        while ((q.size() != 0 || done_at >= 0) && t < 100) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, st, os, oe, rd);
            t++;
        end
        if (t >= 100) begin
            n_chk++;
            $display("FAIL drain_timeout: buffer not empty after %0d cycles, required empty", t);
        end
    endtask

    typedef struct {
        logic we, re;
        logic [31:0] addr, wd;
        logic exp_stall, exp_empty, chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt[12];

    initial begin
        logic st, os, oe;
        logic [31:0] rd;
        int j;

        // Stores then loads: forwarding, youngest-wins, load alongside a drain.
        vt[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'h10, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 1'b1, 32'h40, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10000010};
        vt[3]  = '{1'b0, 1'b1, 32'h13, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[4]  = '{1'b0, 1'b1, 32'h10, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[5]  = '{1'b1, 1'b0, 32'h20, 32'h1,        1'b0, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'h20, 32'h2,        1'b0, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 32'h20, 32'h0,        1'b0, 1'b0, 1'b1, 32'h2};
        vt[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 32'h20, 32'h0,        1'b0, 1'b0, 1'b1, 32'h2};
        vt[10] = '{1'b0, 1'b1, 32'h21, 32'h0,        1'b0, 1'b0, 1'b1, 32'h2};
        vt[11] = '{1'b0, 1'b1, 32'h20, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2};

        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, st, os, oe, rd);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, st, os, oe, rd);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, st, os, oe, rd);
        check("reset_sb_empty", 32'(oe), 32'd1);
        check("reset_stall", 32'(os), 32'd0);
        check("reset_stall_count", bus.StallCount, 32'd0);

        // Give every RAM word a known value.
        for (int i = 0; i < 128; i++) store(32'(i * 4), 32'h10000000 + 32'(i));
        drain();

        foreach (vt[i]) begin
            step(1'b0, vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, st, os, oe, rd);
            check($sformatf("vec%0d_stall", i), 32'(os), 32'(vt[i].exp_stall));
            check($sformatf("vec%0d_empty", i), 32'(oe), 32'(vt[i].exp_empty));
            if (vt[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
        end

        // Back-to-back stores from idle: only the full, non-draining cycle stalls.
        j = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'((48 + j) * 4), 32'hC0DE0000 + 32'(j), st, os, oe, rd);
            check($sformatf("burst%0d_stall", k), 32'(os), 32'(k == 6));
            if (k != 6) j++;
        end
        drain();
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'((48 + k) * 4), 32'd0, st, os, oe, rd);
            check($sformatf("burst_ram%0d", k), rd, 32'hC0DE0000 + 32'(k));
        end

        // Reset on the cycle the head would commit: write aborted, buffer flushed.
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b0, 32'((40 + k) * 4), 32'hBAD00000 + 32'(k), st, os, oe, rd);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, st, os, oe, rd);
        step(1'b0, 1'b0, 1'b1, 32'(40 * 4), 32'd0, st, os, oe, rd);
        check("rst_mid_sb_empty", 32'(oe), 32'd1);
        check("rst_mid_stall", 32'(os), 32'd0);
        check("rst_mid_ram", rd, 32'h10000028);
        check("rst_mid_fwd_count", bus.FwdCount, 32'd0);

        // Random traffic over a narrow index window to force hits and stalls.
        for (int n = 0; n < 1200; n++) begin
            int r;
            logic we, re, rb;
            logic [31:0] a;
            r  = $urandom_range(0, 199);
            rb = (r == 0);
            we = (r >= 1) && (r < 100);
            re = (r >= 100) && (r < 180);
            a  = 32'((60 + $urandom_range(0, 7)) * 4) + 32'($urandom_range(0, 3));
            step(rb, we, re, a, $urandom, st, os, oe, rd);
        end
        drain();
        for (int k = 60; k < 68; k++) step(1'b0, 1'b0, 1'b1, 32'(k * 4), 32'd0, st, os, oe, rd);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
